// File: rtl/debug_ctrl.sv
// UART-driven debug controller: receives 8N1 command bytes, parses halt/continue/step/breakpoint
// commands and drives the CPU halt request from commands, single-step and breakpoint matches.
module debug_ctrl #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic [15:0] pc,
    input  logic        fetch,
    output logic        halt,
    output logic [15:0] bp_addr,
    output logic        bp_enable,
    output logic        cmd_error
);
    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {P_IDLE, P_ADDR} p_state_t;

    rx_state_t   rx_state, rx_next;
    p_state_t    p_state, p_next;
    logic        rx_meta, rx_sync;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  rx_shift, rx_byte;
    logic        rx_valid, baud_tick, frame_err;
    logic [1:0]  nib_cnt;
    logic [15:0] shadow;
    logic        step_pending;
    logic        is_hex, parse_err, load_bp;
    logic [3:0]  nib;
    logic        cmd_h, cmd_c, cmd_s, cmd_x, cmd_b;
    logic        bp_hit, step_hit;

    // Receiver next state; start bit is re-checked at its midpoint to reject glitches.
    always_comb begin
        rx_next   = rx_state;
        frame_err = 1'b0;
        baud_tick = (baud_cnt == ((rx_state == RX_START) ? HALF_END : BIT_END));
        case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_next = RX_START;
            RX_START: if (baud_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (baud_tick && bit_cnt == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (baud_tick) begin
                    rx_next   = RX_IDLE;
                    frame_err = !rx_sync;
                end
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_state <= rx_next;
            rx_valid <= 1'b0;
            if (rx_next != rx_state || rx_state == RX_IDLE) begin
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (baud_tick) begin
                baud_cnt <= '0;
                bit_cnt  <= bit_cnt + 3'd1;
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
            if (rx_state == RX_DATA && baud_tick)
                rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_state == RX_STOP && baud_tick && rx_sync) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        is_hex = 1'b1;
        nib    = rx_byte[3:0];
        if (rx_byte >= "0" && rx_byte <= "9")
            nib = rx_byte[3:0];
        else if ((rx_byte >= "A" && rx_byte <= "F") || (rx_byte >= "a" && rx_byte <= "f"))
            nib = rx_byte[3:0] + 4'd9;
        else
            is_hex = 1'b0;
    end

    always_comb begin
        p_next    = p_state;
        parse_err = 1'b0;
        load_bp   = 1'b0;
        cmd_h     = 1'b0;
        cmd_c     = 1'b0;
        cmd_s     = 1'b0;
        cmd_x     = 1'b0;
        cmd_b     = 1'b0;
        if (rx_valid) begin
            case (p_state)
                P_IDLE: begin
                    case (rx_byte)
                        "H":     cmd_h = 1'b1;
                        "C":     cmd_c = 1'b1;
                        "S":     cmd_s = 1'b1;
                        "X":     cmd_x = 1'b1;
                        "B": begin
                            cmd_b  = 1'b1;
                            p_next = P_ADDR;
                        end
                        default: parse_err = 1'b1;
                    endcase
                end
                P_ADDR: begin
                    if (!is_hex) begin
                        parse_err = 1'b1;
                        p_next    = P_IDLE;
                    end else if (nib_cnt == 2'd3) begin
                        load_bp = 1'b1;
                        p_next  = P_IDLE;
                    end
                end
                default: p_next = P_IDLE;
            endcase
        end
    end

    // Fetches are ignored while halted, so step and breakpoint only fire on a running CPU.
    assign bp_hit   = fetch && bp_enable && (pc == bp_addr) && !halt;
    assign step_hit = fetch && step_pending && !halt;

    always_ff @(posedge clk) begin
        if (reset) begin
            p_state      <= P_IDLE;
            nib_cnt      <= '0;
            shadow       <= '0;
            halt         <= 1'b0;
            step_pending <= 1'b0;
            bp_addr      <= '0;
            bp_enable    <= 1'b0;
            cmd_error    <= 1'b0;
        end else begin
            p_state   <= p_next;
            cmd_error <= frame_err | parse_err;
            if (cmd_b || parse_err) begin
                nib_cnt <= '0;
                shadow  <= '0;
            end else if (rx_valid && p_state == P_ADDR) begin
                nib_cnt <= nib_cnt + 2'd1;
                shadow  <= {shadow[11:0], nib};
            end
            if (load_bp) begin
                bp_addr   <= {shadow[11:0], nib};
                bp_enable <= 1'b1;
            end else if (cmd_x) begin
                bp_enable <= 1'b0;
            end
            // Halt sources take priority over a same-cycle continue.
            if (cmd_h || bp_hit || step_hit)
                halt <= 1'b1;
            else if (cmd_c || (cmd_s && halt))
                halt <= 1'b0;
            if (cmd_c || step_hit)
                step_pending <= 1'b0;
            else if (cmd_s && halt)
                step_pending <= 1'b1;
        end
    end
endmodule

// File: doc/debug_ctrl.md
DEBUG_CTRL -- requirements
Module: debug_ctrl

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 217, clk cycles per UART bit (25 MHz / 115200 baud); legal range 4..65535.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous reset, active-high.
REQ-004 Port: rx  input  1  UART serial in, 8N1, idle high, asynchronous to clk.
REQ-005 Port: pc  input  16  CPU program counter, valid when fetch=1.
REQ-006 Port: fetch  input  1  one-clk pulse per CPU instruction fetch.
REQ-007 Port: halt  output  1  registered CPU halt request; feeds the debug UART reporter's halt input.
REQ-008 Port: bp_addr  output  16  registered breakpoint address.
REQ-009 Port: bp_enable  output  1  registered breakpoint armed flag.
REQ-010 Port: cmd_error  output  1  one-clk pulse on rejected byte or framing error.
REQ-011 One clock domain (clk); reset synchronous, active-high.

Function -- UART receiver
REQ-012 rx SHALL pass a 2-flop synchronizer before any use.
REQ-013 RX states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
REQ-014 RX_IDLE -> RX_START on synchronized rx = 0.
REQ-015 RX_START: rx resampled after CLKS_PER_BIT/2 (integer division) cycles; 0 -> RX_DATA, 1 -> RX_IDLE (glitch, no error).
REQ-016 RX_DATA: 8 samples, one every CLKS_PER_BIT cycles, LSB first.
REQ-017 RX_STOP: sample after CLKS_PER_BIT cycles; 1 -> byte valid for exactly one clk; 0 -> byte discarded, cmd_error pulse; either way -> RX_IDLE.
REQ-018 Baud counter 16 bits; bit counter 3 bits; both cleared on every state entry.

Function -- command parser
REQ-019 Parser states: P_IDLE, P_ADDR (collecting 4 hex nibbles, nibble counter 0..3).
REQ-020 Commands (ASCII, case-sensitive): 'H' halt=1; 'C' halt=0 and step_pending=0; 'S' single-step; 'B' -> P_ADDR; 'X' bp_enable=0.
REQ-021 Any other byte in P_IDLE: cmd_error pulse, no state change.
REQ-022 P_ADDR accepts 0-9, A-F, a-f; nibbles shifted in MSB first into a shadow register.
REQ-023 4th valid nibble: bp_addr <= shadow, bp_enable <= 1, -> P_IDLE.
REQ-024 Non-hex byte in P_ADDR: cmd_error pulse, shadow discarded, bp_addr/bp_enable unchanged, -> P_IDLE; the byte is not re-interpreted as a command.
REQ-025 Latency: halt, bp_addr and bp_enable update on the clk edge after the byte-valid cycle.

Function -- halt control
REQ-026 'S' while halt=1: halt <= 0, step_pending <= 1. 'S' while halt=0: ignored, no error.
REQ-027 fetch=1 with step_pending=1: halt <= 1, step_pending <= 0 on the next edge.
REQ-028 fetch=1, bp_enable=1, pc==bp_addr, halt=0: halt <= 1 on the next edge.
REQ-029 Breakpoint match and 'C' command effect in the same cycle: halt=1 (halt sources win).
REQ-030 'H' while halted, 'C' while running: idempotent, no error.
REQ-031 fetch pulses while halt=1 SHALL be ignored.
REQ-032 cmd_error SHALL be low in every cycle without an error event.

Reset
REQ-033 reset=1 at any clk edge: halt=0, bp_enable=0, bp_addr=16'h0000, cmd_error=0, step_pending=0, RX_IDLE, P_IDLE, counters and shadow cleared, synchronizer flops=1.
REQ-034 Reset mid-frame or mid-'B' sequence SHALL abort it; bytes already received are not applied.
REQ-035 First start bit accepted starting the clk after reset deasserts.

Verification (bench CLKS_PER_BIT=4)
REQ-036 Send 'H' (8'h48) -> halt=1 one clk after stop-bit sample; cmd_error stays 0.
REQ-037 Send "B01A3", then fetch with pc=16'h01A3 -> bp_addr=16'h01A3, bp_enable=1; halt=1 the next edge; fetch with pc=16'h01A2 beforehand -> halt stays 0.
REQ-038 Halted, send 'S', then two fetch pulses -> halt=0 after 'S', halt=1 after the first fetch; second fetch ignored.
REQ-039 Send "B0G" -> one cmd_error pulse on 'G'; bp_addr=16'h0000, bp_enable=0; following 'H' accepted normally.
REQ-040 Frame with stop bit=0 -> cmd_error pulse, no command applied; 1-cycle rx low glitch -> no byte, no error.
REQ-041 Assert reset after 2 nibbles of "B12.." -> all outputs at reset values; subsequent "B0040" loads 16'h0040.
